// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// Shares the single physical memory port between the I-side and D-side
// caches. One line-sized read or write is in flight at a time. Each
// response pulse goes only to the side that owns the transaction.
//
// Optional build macro: ARB_RR_EN
//   undefined : fixed priority, the D-side wins simultaneous requests
//   defined   : round-robin on simultaneous requests, using a 1-bit
//               last-grant register that resets to the I-side
//
// Address, write data and op are captured on the grant edge. The memory
// side is driven only from those registers, so a requester may change or
// drop its live inputs once it has been granted.

module lc3b_mem_arbiter #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_e;

    state_e                  state_r;
    state_e                  state_s;

    // Memory-side registers: these are the transaction latch and also
    // drive the pmem outputs directly.
    logic                    pmem_read_r;
    logic                    pmem_write_r;
    logic [ADDR_WIDTH-1:0]   pmem_address_r;
    logic [LINE_WIDTH-1:0]   pmem_wdata_r;
    logic                    busy_r;

    logic                    i_req_s;
    logic                    d_req_s;
    logic                    grant_d_s;
    logic                    grant_s;
    logic                    lat_write_s;
    logic [ADDR_WIDTH-1:0]   lat_addr_s;
    logic [LINE_WIDTH-1:0]   lat_wdata_s;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;

`ifdef ARB_RR_EN
    // 1 when the D-side received the most recent grant
    logic last_grant_d_r;

    // Winner selection: on a tie, the side that was not granted last wins
    always_comb begin
        grant_d_s = 1'b0;
        if (d_req_s && i_req_s) begin
            grant_d_s = ~last_grant_d_r;
        end else begin
            grant_d_s = d_req_s;
        end
    end

    // Record which side won each grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_d_r <= 1'b0;
        end else if (grant_s) begin
            last_grant_d_r <= grant_d_s;
        end else begin
            last_grant_d_r <= last_grant_d_r;
        end
    end
`else
    // Winner selection: fixed priority, the D-side wins any tie
    always_comb begin
        grant_d_s = 1'b0;
        if (d_req_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end
`endif

    // Next-state logic and the values captured on a grant
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        lat_write_s = 1'b0;
        lat_addr_s  = i_addr;
        lat_wdata_s = {LINE_WIDTH{1'b0}};

        // d_read and d_write together is a protocol error and is taken as a write
        if (grant_d_s) begin
            lat_write_s = d_write;
            lat_addr_s  = d_addr;
            lat_wdata_s = d_wdata;
        end else begin
            lat_write_s = 1'b0;
            lat_addr_s  = i_addr;
            lat_wdata_s = {LINE_WIDTH{1'b0}};
        end

        case (state_r)
            IDLE: begin
                if (i_req_s || d_req_s) begin
                    grant_s = 1'b1;
                    if (grant_d_s) begin
                        state_s = SERVE_D;
                    end else begin
                        state_s = SERVE_I;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVE_D;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Strobes and transaction latch: set on grant, strobes cleared on pmem_resp
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= {ADDR_WIDTH{1'b0}};
            pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
        end else if (grant_s) begin
            pmem_read_r    <= ~lat_write_s;
            pmem_write_r   <= lat_write_s;
            pmem_address_r <= lat_addr_s;
            pmem_wdata_r   <= lat_wdata_s;
        end else if ((state_r != IDLE) && pmem_resp) begin
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= pmem_address_r;
            pmem_wdata_r   <= pmem_wdata_r;
        end else begin
            pmem_read_r    <= pmem_read_r;
            pmem_write_r   <= pmem_write_r;
            pmem_address_r <= pmem_address_r;
            pmem_wdata_r   <= pmem_wdata_r;
        end
    end

    // Busy flag: high whenever the next state is not IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
        end
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign busy         = busy_r;

    // Responses pass straight through to the owning side with no added
    // latency. A pmem_resp seen in IDLE reaches neither side.
    assign i_resp  = pmem_resp & (state_r == SERVE_I);
    assign d_resp  = pmem_resp & (state_r == SERVE_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter. The bench acts as physical
// memory and as both requesters. A transaction-level model tracks each
// side's outstanding request, picks the winner from the arbitration rules
// and predicts the strobes, address, write data and response for every cycle.
module tb_lc3b_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          busy;

    lc3b_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: outstanding request per side, held until its resp
    bit            pi, pd, p_dr, p_dw;
    logic [AW-1:0] p_ia, p_da;
    logic [LW-1:0] p_dwd;
    bit            last_d;
    bit            won_d;
    logic [LW-1:0] rd_pat;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_pending();
        i_read  = pi;
        i_addr  = p_ia;
        d_read  = pd & p_dr;
        d_write = pd & p_dw;
        d_addr  = p_da;
        d_wdata = p_dwd;
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_pread"}, pmem_read, 1'b0);
        chk1({tag, "_pwrite"}, pmem_write, 1'b0);
        chk1({tag, "_iresp"}, i_resp, 1'b0);
        chk1({tag, "_dresp"}, d_resp, 1'b0);
    endtask

    // Service cycles of the granted transaction. scr: 0 keep live inputs,
    // 1 alter winner's addr/wdata, 2 alter and sometimes drop the request.
    task automatic serve(input int lat, input int scr);
        bit            wr;
        bit            last;
        logic [AW-1:0] a;
        wr = won_d ? p_dw : 1'b0;
        a  = won_d ? p_da : p_ia;
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            last = (k == lat);
            if (scr != 0) begin
                if (won_d) begin
                    d_addr  = (k == 1) ? (a ^ 16'h1000) : 16'($urandom);
                    d_wdata = {$urandom, $urandom, $urandom, $urandom};
                    if (scr == 2 && $urandom_range(0, 3) == 0) begin
                        d_read  = 1'b0;
                        d_write = 1'b0;
                    end
                end else begin
                    i_addr = (k == 1) ? (a ^ 16'h1000) : 16'($urandom);
                    if (scr == 2 && $urandom_range(0, 3) == 0) begin
                        i_read = 1'b0;
                    end
                end
            end
            pmem_resp  = last;
            rd_pat     = {$urandom, $urandom, $urandom, $urandom};
            pmem_rdata = rd_pat;
            #1;
            chk1("srv_pread", pmem_read, !wr);
            chk1("srv_pwrite", pmem_write, wr);
            chka("srv_addr", pmem_address, a);
            if (wr) chkd("srv_wdata", pmem_wdata, p_dwd);
            chk1("srv_busy", busy, 1'b1);
            chk1("srv_iresp", i_resp, last && !won_d);
            chk1("srv_dresp", d_resp, last && won_d);
            if (last && won_d) chkd("srv_drdata", d_rdata, rd_pat);
            if (last && !won_d) chkd("srv_irdata", i_rdata, rd_pat);
        end
        if (won_d) pd = 1'b0;
        else       pi = 1'b0;
    endtask

    // One IDLE cycle followed by the chosen transaction (if any request)
    task automatic run_round(input int lat, input int scr);
        next_cycle();
        drive_pending();
        pmem_resp  = (!pi && !pd) ? 1'($urandom_range(0, 1)) : 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check_idle("idle");
        if (pi || pd) begin
            if (pi && pd) begin
`ifdef ARB_RR_EN
                won_d = !last_d;
`else
                won_d = 1'b1;
`endif
            end else begin
                won_d = pd;
            end
            last_d = won_d;
            serve(lat, scr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pi = 1'b0; pd = 1'b0;
        drive_pending();
        pmem_resp = 1'b0;
        #1;
        check_idle("rst");
        chka("rst_addr", pmem_address, 16'h0000);
        chkd("rst_wdata", pmem_wdata, {LW{1'b0}});
        #1;
        reset_n = 1'b1;
        last_d  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset_n = 1'b0;
        pi = 1'b0; pd = 1'b0; p_dr = 1'b0; p_dw = 1'b0;
        p_ia = 16'h0000; p_da = 16'h0000; p_dwd = {LW{1'b0}};
        last_d = 1'b0; won_d = 1'b0;
        drive_pending();
        pmem_resp = 1'b0;
        pmem_rdata = {LW{1'b0}};
        #2;
        check_idle("por");
        chka("por_addr", pmem_address, 16'h0000);
        chkd("por_wdata", pmem_wdata, {LW{1'b0}});
        @(negedge clk);
        reset_n = 1'b1;

        // Single I read at 0x1230, memory latency 3
        pi = 1'b1; p_ia = 16'h1230;
        run_round(3, 0);

        // D write to 0x4000, live address moved to 0x5000 after grant
        pd = 1'b1; p_dr = 1'b0; p_dw = 1'b1; p_da = 16'h4000;
        p_dwd = {16{8'hA5}};
        run_round(3, 1);
        run_round(1, 0);

        // Simultaneous requests, both held
        do_reset();
        pi = 1'b1; p_ia = 16'h0AA0;
        pd = 1'b1; p_dr = 1'b1; p_dw = 1'b0; p_da = 16'h0DD0;
`ifdef ARB_RR_EN
        for (int n = 0; n < 4; n++) begin
            run_round(2, 0);
            chk1("rr_order", won_d, (n % 2) == 0);
            pi = 1'b1; pd = 1'b1;
        end
        pi = 1'b0; pd = 1'b0;
`else
        run_round(2, 0);
        chk1("fp_first_d", d_resp, 1'b1);
        run_round(2, 0);
        chk1("fp_second_i", i_resp, 1'b1);
`endif

        // STI-style: D read then D write issued right after the resp
        pd = 1'b1; p_dr = 1'b1; p_dw = 1'b0; p_da = 16'h0100;
        run_round(2, 0);
        pd = 1'b1; p_dr = 1'b0; p_dw = 1'b1; p_da = 16'h0200;
        p_dwd = {$urandom, $urandom, $urandom, $urandom};
        run_round(2, 0);

        // Reset asserted in the second SERVE_D cycle
        pd = 1'b1; p_dr = 1'b0; p_dw = 1'b1; p_da = 16'h2468;
        next_cycle();
        drive_pending();
        pmem_resp = 1'b0;
        #1;
        check_idle("rmid_idle");
        next_cycle();
        #1;
        chk1("rmid_c1_pwrite", pmem_write, 1'b1);
        next_cycle();
        #1;
        chk1("rmid_c2_pwrite", pmem_write, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk1("rmid_pwrite", pmem_write, 1'b0);
        chk1("rmid_busy", busy, 1'b0);
        chk1("rmid_dresp", d_resp, 1'b0);
        pd = 1'b0;
        drive_pending();
        #1;
        reset_n = 1'b1;
        last_d  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            #1;
            check_idle("rmid_after");
        end

        // Spurious pmem_resp in IDLE
        next_cycle();
        pmem_resp = 1'b1;
        #1;
        check_idle("spur");
        next_cycle();
        pmem_resp = 1'b0;
        #1;
        check_idle("spur_after");

        // Randomized traffic against the model
        for (int r = 0; r < 300; r++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1;
                p_ia = 16'($urandom);
            end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1'b1;
                case ($urandom_range(0, 3))
                    0, 1:    begin p_dr = 1'b1; p_dw = 1'b0; end
                    2:       begin p_dr = 1'b0; p_dw = 1'b1; end
                    default: begin p_dr = 1'b1; p_dw = 1'b1; end
                endcase
                p_da  = 16'($urandom);
                p_dwd = {$urandom, $urandom, $urandom, $urandom};
            end
            run_round($urandom_range(1, 4), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
